wb_stage: RTL

- Writeback stage between the memory stage and the register file.
- Accepts one retiring instruction at a time and waits for load data when needed.
- Aligns and sign/zero-extends load data, then drives the register-file write port (wen/waddr/wdata) for exactly one cycle per instruction.
- Register-file outputs are registered off posedge clk. The register file samples them on its own edge and bypasses them combinationally to decode.

---
 rtl/wb_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction, waits for load data,
// extends it and drives a registered register-file write port. Optional WB_INSTRET_EN.
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_wen,
    input  logic                 in_is_load,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic [XLEN-1:0]      in_result,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_wen_q, rd_wen_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic            rf_wen_q, rf_wen_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            retire_q, retire_d;

    logic            acc;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign in_ready = (state_q != S_WAIT);
    assign acc      = in_valid & in_ready & ~flush;

    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        rd_wen_d   = rd_wen_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        rf_wen_d   = 1'b0;
        retire_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d    = S_WRITE;
                    rf_wen_d   = rd_wen_q & (rd_q != 5'd0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = ld_data;
                    retire_d   = 1'b1;
                end
            end
            default: begin
                // EMPTY and WRITE accept alike, allowing back-to-back retirement
                if (acc) begin
                    rd_d      = in_rd;
                    rd_wen_d  = in_rd_wen;
                    funct3_d  = in_funct3;
                    addr_lo_d = in_addr_lo;
                    if (in_is_load) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_WRITE;
                        rf_wen_d   = in_rd_wen & (in_rd != 5'd0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = in_result;
                        retire_d   = 1'b1;
                    end
                end else begin
                    state_d = S_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            rd_q       <= 5'd0;
            rd_wen_q   <= 1'b0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= '0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            rd_wen_q   <= rd_wen_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retire_q   <= retire_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign retire   = retire_q;

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;

    assign instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
